// File: rtl/apb_keypad_scanner_if.sv
// APB slave bus bundle for the keypad scanner: address/data/handshake signals
// that travel together between bus master and peripheral.
interface apb_keypad_scanner_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/apb_keypad_scanner.sv
// ROWSxCOLS matrix keypad scanner: row-at-a-time scan, whole-frame debounce,
// press/release event FIFO and level interrupt behind an APB slave port.
module apb_keypad_scanner #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COLS-1:0]     col_in,
    output logic [ROWS-1:0]     row,
    output logic                irq,
    apb_keypad_scanner_if.slave apb
);
    localparam int NKEYS = ROWS * COLS;
    localparam int DW    = $clog2(SCAN_DIV);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, COMMIT} state_t;

    typedef struct packed {
        logic       press;
        logic [7:0] idx;
    } evt_t;

    state_t           state, state_nx;
    logic [DW-1:0]    div;
    logic [RW-1:0]    r;
    logic [KW-1:0]    k;
    logic [NKEYS-1:0] raw, prev, keys;
    logic [3:0]       stable, stable_nx;
    logic [2:0]       ctrl;
    logic             ovf;

    evt_t             mem [FIFO_DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;

    logic div_last, r_last, k_last;
    logic rd_acc, wr_acc, pop, push, do_push, full;
    evt_t evt;

    assign div_last = (div == DW'(SCAN_DIV - 1));
    assign r_last   = (r == RW'(ROWS - 1));
    assign k_last   = (k == KW'(NKEYS - 1));

    assign rd_acc = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign wr_acc = apb.PSEL & apb.PENABLE & apb.PWRITE;

    assign stable_nx = (raw != prev)    ? 4'd1 :
                       (stable == 4'hF) ? 4'hF : stable + 4'd1;

    assign row = (state == DRIVE) ? (ROWS'(1) << r) : '0;

    // Scan FSM: next state
    always_comb begin
        state_nx = state;
        if (!ctrl[0]) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = DRIVE;
                DRIVE:   if (div_last && r_last) state_nx = CHECK;
                CHECK:   state_nx = (stable_nx == 4'(DEBOUNCE) && raw != keys) ? COMMIT : DRIVE;
                COMMIT:  if (k_last) state_nx = DRIVE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            div    <= '0;
            r      <= '0;
            k      <= '0;
            raw    <= '0;
            prev   <= '0;
            stable <= '0;
            keys   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                DRIVE: begin
                    if (div_last) begin
                        raw[r*COLS +: COLS] <= col_in;
                        div <= '0;
                        r   <= r_last ? '0 : r + RW'(1);
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                CHECK: begin
                    stable <= stable_nx;
                    prev   <= raw;
                end
                COMMIT: begin
                    keys[k] <= raw[k];
                    k       <= k_last ? '0 : k + KW'(1);
                end
                default: ;
            endcase
            // Leaving for IDLE abandons any partial row or commit walk
            if (state_nx == IDLE) begin
                div <= '0;
                r   <= '0;
                k   <= '0;
            end
        end
    end

    // Commit walk emits one candidate event per key, ascending index
    assign push    = (state == COMMIT) && (raw[k] != keys[k]) && (raw[k] || ctrl[2]);
    assign evt     = '{press: raw[k], idx: 8'(k)};
    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign pop     = rd_acc && (apb.PADDR[3:2] == 2'd1) && (cnt != '0);
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            ctrl <= '0;
            irq  <= 1'b0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (pop)     rp <= rp + AW'(1);
            case ({do_push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: ;
            endcase
            // A dropped push in the same cycle as a W1C keeps the flag set
            if (push && !do_push)
                ovf <= 1'b1;
            else if (wr_acc && apb.PADDR[3:2] == 2'd3 && apb.PWDATA[8])
                ovf <= 1'b0;
            if (wr_acc && apb.PADDR[3:2] == 2'd2)
                ctrl <= apb.PWDATA[2:0];
            irq <= ctrl[1] & ((cnt != '0) | ovf);
        end
    end

    assign apb.PREADY = 1'b1;

    always_comb begin
        apb.PRDATA = '0;
        case (apb.PADDR[3:2])
            2'd0: apb.PRDATA[NKEYS-1:0] = keys;
            2'd1: if (cnt != '0) apb.PRDATA = {1'b1, 22'b0, mem[rp]};
            2'd2: apb.PRDATA[2:0] = ctrl;
            2'd3: apb.PRDATA = {22'b0, (cnt == '0), ovf, 1'b0, 7'(cnt)};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_apb_keypad_scanner.sv
// Randomised scoreboard bench: a behavioural key-matrix model predicts KEYS,
// FIFO contents and irq; a bus monitor checks every EVENT read against the queue.
module tb_apb_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 3, FIFO_DEPTH = 8;
    localparam int NK    = ROWS * COLS;
    localparam int FRAME = ROWS * SCAN_DIV + 1;
    localparam int HOLD  = (DEBOUNCE + 4) * FRAME + NK + 10;

    logic            clk = 0;
    logic            rst = 1;
    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row;
    logic            irq;

    apb_keypad_scanner_if apb();

    apb_keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                         .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .col_in(col_in), .row(row), .irq(irq), .apb(apb));

    always #5 clk = ~clk;

    // Physical matrix: a closed key shorts its row to its column
    logic [NK-1:0] pressed = '0;
    always_comb begin
        col_in = '0;
        for (int rr = 0; rr < ROWS; rr++)
            for (int cc = 0; cc < COLS; cc++)
                if (row[rr] && pressed[rr*COLS+cc]) col_in[cc] = 1'b1;
    end

    int checks = 0, failures = 0;
    logic [31:0]   exp_q[$];
    logic [NK-1:0] model_keys = '0;
    logic          model_ovf = 0, rel_en = 0, irq_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apb_rd(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        apb.PSEL = 1; apb.PWRITE = 0; apb.PADDR = a; apb.PENABLE = 0;
        @(posedge clk); #1;
        apb.PENABLE = 1;
        @(negedge clk);
        d = apb.PRDATA;
        @(posedge clk); #1;
        apb.PSEL = 0; apb.PENABLE = 0;
    endtask

    task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        apb.PSEL = 1; apb.PWRITE = 1; apb.PADDR = a; apb.PWDATA = d; apb.PENABLE = 0;
        @(posedge clk); #1;
        apb.PENABLE = 1;
        @(posedge clk); #1;
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
    endtask

    task automatic set_ctrl(input logic en, input logic ie, input logic re);
        irq_en = ie; rel_en = re;
        apb_wr(4'h8, ($urandom & 32'hFFFF_FFF8) | {29'b0, re, ie, en});
    endtask

    // Behavioural prediction: a held pattern becomes KEYS; changed keys queue in index order
    task automatic apply(input logic [NK-1:0] nw);
        for (int i = 0; i < NK; i++)
            if (model_keys[i] != nw[i] && (nw[i] || rel_en)) begin
                if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({1'b1, 22'b0, nw[i], 8'(i)});
                else model_ovf = 1;
            end
        model_keys = nw;
        pressed = nw;
        repeat (HOLD) @(posedge clk);
    endtask

    task automatic check_state(input string tag);
        logic [31:0] d;
        apb_rd(4'h0, d);
        chk({tag, "_keys"}, d, 32'(model_keys));
        apb_rd(4'hC, d);
        chk({tag, "_stat"}, d, {22'b0, exp_q.size() == 0, model_ovf, 1'b0, 7'(exp_q.size())});
        chk({tag, "_irq"}, 32'(irq), 32'(irq_en && (exp_q.size() != 0 || model_ovf)));
    endtask

    task automatic drain();
        logic [31:0] d;
        int n;
        n = exp_q.size();
        repeat (n + 1) apb_rd(4'h4, d);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        exp_q.delete(); model_keys = '0; model_ovf = 0; irq_en = 0; rel_en = 0;
    endtask

    task automatic check_after_rst(input string tag);
        logic [31:0] d;
        chk({tag, "_row"}, 32'(row), 32'h0);
        chk({tag, "_irq"}, 32'(irq), 32'h0);
        apb_rd(4'h0, d); chk({tag, "_keys"}, d, 32'h0);
        apb_rd(4'hC, d); chk({tag, "_stat"}, d, 32'h200);
    endtask

    // Monitor: every EVENT access phase is scored against the predicted FIFO
    initial forever begin
        @(negedge clk);
        if (apb.PSEL && apb.PENABLE && !apb.PWRITE && apb.PADDR == 4'h4) begin
            if (exp_q.size() != 0) chk("event", apb.PRDATA, exp_q.pop_front());
            else                   chk("event_empty", apb.PRDATA, 32'h0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   d;
        logic [NK-1:0] pat;
        logic          seen;
        int            t;
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
        repeat (3) @(posedge clk); #1 rst = 0;

        check_after_rst("reset");
        chk("pready", 32'(apb.PREADY), 32'h1);

        // Single press of key 5, then release without/with release logging
        set_ctrl(1, 1, 0);
        apply(NK'(1) << 5);
        check_state("press5");
        drain();
        apply('0);
        check_state("rel5_off");
        set_ctrl(1, 1, 1);
        apply(NK'(1) << 5);
        apply('0);
        check_state("rel5_on");
        drain();

        // Bounce faster than the debounce window: nothing may commit
        seen = 0;
        for (int i = 0; i < 10 * FRAME; i++) begin
            if (i % (FRAME * 3 / 2) == 0) pressed[5] = ~pressed[5];
            @(posedge clk); #1;
            if (irq) seen = 1;
        end
        pressed = '0;
        repeat (HOLD) @(posedge clk);
        chk("bounce_irq", 32'(seen), 32'h0);
        check_state("bounce");

        // Two keys in one frame, ascending order
        apply((NK'(1) << 2) | (NK'(1) << 14));
        check_state("two");
        drain();
        apply('0);
        drain();

        // Overflow: 9 presses into an 8-deep FIFO
        set_ctrl(1, 1, 0);
        apply(NK'(16'h01FF));
        check_state("ovf");
        apb_wr(4'hC, 32'h100);
        model_ovf = 0;
        check_state("w1c");
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            apb_rd(4'h4, d);
            @(posedge clk); #1;
            chk("irq_pop", 32'(irq), 32'(exp_q.size() != 0));
        end
        apply('0);

        // Randomised patterns and control settings
        for (int it = 0; it < 30; it++) begin
            set_ctrl(1, 1'($urandom), 1'($urandom));
            apb_rd(4'h8, d);
            chk("ctrl_rb", d, {29'b0, rel_en, irq_en, 1'b1});
            case ($urandom_range(0, 3))
                0: pat = NK'($urandom);
                1: pat = model_keys ^ (NK'(1) << $urandom_range(0, NK - 1));
                2: pat = ($urandom & 1) ? '1 : '0;
                default: pat = NK'($urandom & $urandom);
            endcase
            apply(pat);
            check_state("rand");
            if ($urandom_range(0, 3) == 0) begin
                apb_wr(4'hC, 32'h100);
                model_ovf = 0;
            end
            if ($urandom_range(0, 2) != 0) drain();
        end
        drain();
        set_ctrl(1, 0, 0);
        apply('0);

        // Reset during a commit walk
        pressed = '1;
        t = 0;
        do begin
            apb_rd(4'hC, d);
            t++;
        end while (d[6:0] == 0 && t < 500);
        chk("commit_seen", 32'(d[6:0] != 0), 32'h1);
        pulse_rst();
        pressed = '0;
        check_after_rst("rst_commit");

        // Reset while row 2 is driven
        set_ctrl(1, 1, 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (row != 4'b0100 && t < 500);
        chk("row2_seen", 32'(row), 32'h4);
        pulse_rst();
        check_after_rst("rst_drive");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
